// File: rtl/srdl2sv_b2r_arbiter.sv
// srdl2sv_b2r_arbiter: round-robin sharing of one b2r/r2b register port between two requesters,
// with a forced error response when the register block does not answer in time.
module srdl2sv_b2r_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        rq0_w_vld,
    input  logic        rq1_w_vld,
    input  logic        rq0_r_vld,
    input  logic        rq1_r_vld,
    input  logic [31:0] rq0_addr,
    input  logic [31:0] rq1_addr,
    input  logic [31:0] rq0_data,
    input  logic [31:0] rq1_data,
    input  logic [3:0]  rq0_byte_en,
    input  logic [3:0]  rq1_byte_en,
    output logic        rq0_rdy,
    output logic        rq1_rdy,
    output logic        rq0_err,
    output logic        rq1_err,
    output logic [31:0] rq0_rdata,
    output logic [31:0] rq1_rdata,
    output logic        b2r_w_vld,
    output logic        b2r_r_vld,
    output logic [31:0] b2r_addr,
    output logic [31:0] b2r_data,
    output logic [3:0]  b2r_byte_en,
    input  logic        r2b_rdy,
    input  logic        r2b_err,
    input  logic [31:0] r2b_data,
    output logic        timeout_evt
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        gnt, sel, sw, sr, nxt, done, derr;
    logic [31:0] ddata;

    assign gnt = state_q != IDLE;
    assign sel = state_q == GNT1;
    assign sw  = sel ? rq1_w_vld : rq0_w_vld;
    assign sr  = sel ? rq1_r_vld : rq0_r_vld;
    // On contention the requester that was not granted last time wins.
    assign nxt = ((rq0_w_vld | rq0_r_vld) & (rq1_w_vld | rq1_r_vld)) ? ~last_q : (rq1_w_vld | rq1_r_vld);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        derr        = 1'b0;
        ddata       = '0;
        timeout_evt = 1'b0;
        b2r_w_vld   = gnt & sw & ~sr;
        b2r_r_vld   = gnt & sr & ~sw;
        b2r_addr    = !gnt ? '0 : sel ? rq1_addr : rq0_addr;
        b2r_data    = !gnt ? '0 : sel ? rq1_data : rq0_data;
        b2r_byte_en = !gnt ? '0 : sel ? rq1_byte_en : rq0_byte_en;
        if (!gnt) begin
            if (rq0_w_vld | rq0_r_vld | rq1_w_vld | rq1_r_vld) begin
                state_d = nxt ? GNT1 : GNT0;
                last_d  = nxt;
                cnt_d   = '0;
            end
        end else if (sw & sr) begin
            done    = 1'b1;
            derr    = 1'b1;
            state_d = IDLE;
        end else if (!(sw | sr)) begin
            state_d = IDLE;
        end else if (r2b_rdy) begin
            done    = 1'b1;
            derr    = r2b_err;
            ddata   = r2b_data;
            state_d = IDLE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            done        = 1'b1;
            derr        = 1'b1;
            timeout_evt = 1'b1;
            state_d     = IDLE;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign rq0_rdy   = done & ~sel;
    assign rq1_rdy   = done & sel;
    assign rq0_err   = derr & ~sel;
    assign rq1_err   = derr & sel;
    assign rq0_rdata = sel ? '0 : ddata;
    assign rq1_rdata = sel ? ddata : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_srdl2sv_b2r_arbiter.sv
// tb_srdl2sv_b2r_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model of who owns the port and for how long.
module tb_srdl2sv_b2r_arbiter;
    localparam int T = 4;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [1:0]  w = '0, r = '0;
    logic [31:0] addr [2], data [2];
    logic [3:0]  be [2];
    logic        r2b_rdy = 1'b0, r2b_err = 1'b0;
    logic [31:0] r2b_data = '0;
    logic [1:0]  rdy, err;
    logic [31:0] rdata [2];
    logic        b2r_w_vld, b2r_r_vld, timeout_evt;
    logic [31:0] b2r_addr, b2r_data;
    logic [3:0]  b2r_byte_en;

    int n_cmp = 0, n_err = 0;
    int owner = -1, last = 1, age = 0, nxt;
    int rvc = 0, tc = 0;
    logic [31:0] gq [$];

    logic        e_w, e_r, e_tmo;
    logic [31:0] e_a, e_d;
    logic [3:0]  e_b;
    logic [1:0]  e_rdy = '0, e_err;
    logic [31:0] e_rd [2];

    srdl2sv_b2r_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .rq0_w_vld(w[0]), .rq1_w_vld(w[1]), .rq0_r_vld(r[0]), .rq1_r_vld(r[1]),
        .rq0_addr(addr[0]), .rq1_addr(addr[1]), .rq0_data(data[0]), .rq1_data(data[1]),
        .rq0_byte_en(be[0]), .rq1_byte_en(be[1]),
        .rq0_rdy(rdy[0]), .rq1_rdy(rdy[1]), .rq0_err(err[0]), .rq1_err(err[1]),
        .rq0_rdata(rdata[0]), .rq1_rdata(rdata[1]),
        .b2r_w_vld(b2r_w_vld), .b2r_r_vld(b2r_r_vld), .b2r_addr(b2r_addr),
        .b2r_data(b2r_data), .b2r_byte_en(b2r_byte_en),
        .r2b_rdy(r2b_rdy), .r2b_err(r2b_err), .r2b_data(r2b_data),
        .timeout_evt(timeout_evt)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rq(input int i, input logic wv, input logic rv, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        w[i] = wv; r[i] = rv; addr[i] = a; data[i] = d; be[i] = b;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        owner = -1; last = 1; age = 0; e_rdy = '0;
        HRESETn = 1'b1;
    endtask

    // One clock: predict the visible outcome of this cycle, compare, then advance the model.
    task automatic cycle();
        int x;
        @(negedge HCLK);
        {e_w, e_r, e_tmo, e_a, e_d, e_b, e_rdy, e_err} = '0;
        e_rd[0] = '0; e_rd[1] = '0;
        nxt = -1;
        if (owner < 0) begin
            if ((w[0] | r[0]) && (w[1] | r[1])) nxt = 1 - last;
            else if (w[0] | r[0]) nxt = 0;
            else if (w[1] | r[1]) nxt = 1;
        end else begin
            x = owner;
            e_a = addr[x]; e_d = data[x]; e_b = be[x];
            e_w = w[x] & ~r[x]; e_r = r[x] & ~w[x];
            if (w[x] & r[x]) begin
                e_rdy[x] = 1'b1; e_err[x] = 1'b1;
            end else if (!(w[x] | r[x])) begin
            end else if (r2b_rdy) begin
                e_rdy[x] = 1'b1; e_err[x] = r2b_err; e_rd[x] = r2b_data;
            end else if (age == T - 1) begin
                e_rdy[x] = 1'b1; e_err[x] = 1'b1; e_tmo = 1'b1;
            end else nxt = x;
        end
        chk("b2r_w_vld", b2r_w_vld, e_w);
        chk("b2r_r_vld", b2r_r_vld, e_r);
        chk("b2r_addr", b2r_addr, e_a);
        chk("b2r_data", b2r_data, e_d);
        chk("b2r_byte_en", b2r_byte_en, e_b);
        chk("rq_rdy", rdy, e_rdy);
        chk("rq_err", err, e_err);
        chk("rq0_rdata", rdata[0], e_rd[0]);
        chk("rq1_rdata", rdata[1], e_rd[1]);
        chk("timeout_evt", timeout_evt, e_tmo);
        if (b2r_r_vld) rvc++;
        if (timeout_evt) tc++;
        if (b2r_w_vld) gq.push_back(b2r_addr);
        @(posedge HCLK);
        if (owner < 0 && nxt >= 0) begin last = nxt; age = 0; end
        else if (owner >= 0 && nxt >= 0) age++;
        owner = nxt;
        #1;
    endtask

    task automatic drive_random();
        int k;
        for (int i = 0; i < 2; i++) begin
            if (e_rdy[i] || !(w[i] | r[i])) begin
                k = $urandom_range(15, 0);
                set_rq(i, k < 7 || k == 14, (k >= 7 && k < 14) || k == 14, $urandom, $urandom,
                       4'($urandom));
            end else if ($urandom_range(39, 0) == 0) begin
                w[i] = 1'b0; r[i] = 1'b0;
            end
        end
        r2b_rdy  = $urandom_range(3, 0) == 0;
        r2b_err  = 1'($urandom);
        r2b_data = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) set_rq(i, 0, 0, 0, 0, 0);
        cycle();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // read on rq0 answered on the third grant cycle
        set_rq(0, 0, 1, 32'h10, 0, 4'hf);
        rvc = 0;
        cycle(); cycle(); cycle();
        r2b_rdy = 1'b1; r2b_data = 32'hA5A5_0001; r2b_err = 1'b0;
        cycle();
        chk("read_grant_cycles", rvc, 3);
        set_rq(0, 0, 0, 0, 0, 0);
        r2b_rdy = 1'b0;
        cycle();

        // both writing from reset with instant completion: alternate grants
        set_rq(0, 1, 0, 32'h100, 32'h1, 4'h3);
        set_rq(1, 1, 0, 32'h200, 32'h2, 4'hc);
        r2b_rdy = 1'b1;
        do_reset();
        gq.delete();
        repeat (8) cycle();
        chk("rr_grants", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], (i % 2) ? 32'h200 : 32'h100);
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        r2b_rdy = 1'b0;
        cycle();

        // rq1 write never answered: forced error on the 4th grant cycle
        set_rq(1, 1, 0, 32'h44, 32'h55, 4'hf);
        tc = 0;
        repeat (5) cycle();
        chk("timeout_count", tc, 1);
        set_rq(1, 0, 0, 0, 0, 0);
        cycle();

        // illegal read+write on rq0
        set_rq(0, 1, 1, 32'h8, 32'h9, 4'h1);
        cycle(); cycle();
        set_rq(0, 0, 0, 0, 0, 0);
        cycle();

        // reset during the second GNT1 cycle, then rq0 wins the first contention
        set_rq(1, 1, 0, 32'h77, 32'h66, 4'hf);
        cycle(); cycle();
        HRESETn = 1'b0;
        #1;
        chk("rst_b2r_w_vld", b2r_w_vld, 0);
        chk("rst_b2r_addr", b2r_addr, 0);
        chk("rst_rq_rdy", rdy, 0);
        chk("rst_rq_err", err, 0);
        set_rq(0, 1, 0, 32'h300, 32'h3, 4'hf);
        set_rq(1, 1, 0, 32'h400, 32'h4, 4'hf);
        do_reset();
        gq.delete();
        cycle();
        r2b_rdy = 1'b1;
        cycle();
        chk("post_rst_grants", gq.size(), 1);
        if (gq.size() > 0) chk("post_rst_first", gq[0], 32'h300);
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        r2b_rdy = 1'b0;
        cycle();

        repeat (600) begin
            drive_random();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/srdl2sv_b2r_arbiter.md
SRDL2SV_B2R_ARBITER -- requirements
Module: srdl2sv_b2r_arbiter

Purpose: shares one register-block access port (b2r/r2b) between two bus widgets (requester 0, requester 1) using round-robin arbitration and a response timeout.

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, range 2..255; maximum grant cycles without r2b_rdy before a forced error response.
REQ-002 SHALL have ports, one per line:
- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous, active-low
- rq0_w_vld, rq1_w_vld  in  1  write request
- rq0_r_vld, rq1_r_vld  in  1  read request
- rq0_addr, rq1_addr  in  32  byte address
- rq0_data, rq1_data  in  32  write data
- rq0_byte_en, rq1_byte_en  in  4  byte enables
- rq0_rdy, rq1_rdy  out  1  transaction complete (1-cycle pulse)
- rq0_err, rq1_err  out  1  error, valid with rdy
- rq0_rdata, rq1_rdata  out  32  read data, valid with rdy
- b2r_w_vld, b2r_r_vld  out  1  downstream write/read request
- b2r_addr, b2r_data  out  32  downstream address / write data
- b2r_byte_en  out  4  downstream byte enables
- r2b_rdy, r2b_err  in  1  downstream completion / error
- r2b_data  in  32  downstream read data
- timeout_evt  out  1  1-cycle pulse on forced timeout

Function
REQ-003 A requester is pending when w_vld|r_vld = 1; it SHALL hold vld, addr, data and byte_en stable until its rdy pulse.
REQ-004 FSM states SHALL be IDLE, GNT0, GNT1.
REQ-005 IDLE: no pending -> IDLE; one pending -> its GNT state next cycle; both pending -> GNT of requester != last_q.
REQ-006 last_q (1 bit) SHALL load the granted index on every IDLE->GNTx transition.
REQ-007 In GNTx, b2r_* SHALL combinationally equal requester x's signals; in IDLE all b2r_* outputs SHALL be 0.
REQ-008 Grant latency: request first sampled in IDLE at cycle N -> b2r vld high at N+1.
REQ-009 In GNTx with r2b_rdy=1: rqx_rdy=1, rqx_err=r2b_err, rqx_rdata=r2b_data same cycle; next state IDLE.
REQ-010 rq_rdy/err SHALL be 0 and rq_rdata 0 for the non-granted requester and in IDLE.
REQ-011 Cycle counter cnt_q (8 bits) SHALL clear on entry to GNTx and increment on every GNTx cycle without r2b_rdy.
REQ-012 If cnt_q = TIMEOUT_CYCLES-1 with r2b_rdy=0: rqx_rdy=1, rqx_err=1, rqx_rdata=0, timeout_evt=1; next state IDLE.
REQ-013 r2b_rdy in the same cycle as timeout SHALL win: normal completion, timeout_evt=0.
REQ-014 Both w_vld and r_vld high on the granted requester: b2r_w_vld=b2r_r_vld=0, rqx_rdy=1, rqx_err=1 in the first GNTx cycle; next state IDLE.
REQ-015 Granted requester drops both vld before completion (abort): b2r vld follows to 0 same cycle; no rdy; next state IDLE.
REQ-016 r2b_rdy in IDLE SHALL be ignored.
REQ-017 Every transaction SHALL return through IDLE; at most one transaction per 2 cycles.

Reset
REQ-018 HRESETn low SHALL asynchronously force state IDLE, last_q=1, cnt_q=0, all outputs 0.
REQ-019 Reset mid-grant SHALL drop b2r vld immediately; no rdy is issued for the aborted transaction.

Verification
REQ-020 rq0 read addr 0x10, r2b_rdy at 3rd grant cycle with data 0xA5A5_0001 -> b2r_r_vld high 3 cycles, rq0_rdy pulse with rq0_rdata 0xA5A5_0001, rq0_err 0.
REQ-021 rq0 and rq1 writes pending from reset, r2b_rdy always 1 -> grants order GNT0, GNT1, GNT0, ... each followed by IDLE.
REQ-022 rq1 write, r2b_rdy never, TIMEOUT_CYCLES=4 -> rq1_rdy=rq1_err=1 and timeout_evt=1 in 4th grant cycle, then IDLE.
REQ-023 rq0 with w_vld=r_vld=1 -> no b2r vld, rq0_rdy=rq0_err=1 on first grant cycle.
REQ-024 HRESETn low in 2nd cycle of GNT1 -> all outputs 0 immediately; after release, simultaneous requests grant rq0 first.
